vga_pattern_sequencer: RTL and testbench



---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_frame_edge.sv | 26 ++
 rtl/vga_pattern_sequencer.sv | 147 ++++++++++++++
 tb/tb_vga_pattern_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern codes, sequencer state encoding and
// the wrap-around pattern stepping helper.
package vga_pkg;

  localparam logic [3:0] PAT_OFF    = 4'd0;
  localparam logic [3:0] PAT_RED    = 4'd1;
  localparam logic [3:0] PAT_GRN    = 4'd2;
  localparam logic [3:0] PAT_BLU    = 4'd3;
  localparam logic [3:0] PAT_CHECK  = 4'd4;
  localparam logic [3:0] PAT_BARS   = 4'd5;
  localparam logic [3:0] PAT_BORDER = 4'd6;

  localparam int NUM_PATTERNS_DEFAULT = 7;

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_AUTO   = 2'd1;
  localparam logic [1:0] S_MANUAL = 2'd2;
  localparam logic [1:0] S_BLANK  = 2'd3;

  // Steps within 1..num-1; code 0 (off) is never produced.
  function automatic logic [3:0] step_pattern(input logic [3:0] pat,
                                              input logic       fwd,
                                              input int         num);
    logic [3:0] last;
    last = 4'(num - 1);
    if (fwd) return (pat >= last) ? PAT_RED : pat + 4'd1;
    else     return (pat <= PAT_RED) ? last : pat - 4'd1;
  endfunction

endpackage

// File: rtl/vga_frame_edge.sv
// Frame boundary detector: registers VSync and pulses frame_start the cycle
// after each rising edge (VSync high = active rows).
module vga_frame_edge (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic frame_edge,
  output logic frame_start
);

  logic vsync_p0;

  assign frame_edge = vsync & ~vsync_p0;

  // Loading 1 on reset suppresses a false edge when reset releases mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_p0    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vsync_p0    <= vsync;
      frame_start <= frame_edge;
    end
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous pattern select for the VGA test pattern generator.
// Optional build macro VGA_SEQ_BLANK_EN inserts one blank frame per change.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int NUM_PATTERNS       = NUM_PATTERNS_DEFAULT,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int FRAME_CNT_WIDTH    = 8
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_VSync,
  input  logic                       i_Enable,
  input  logic                       i_Auto,
  input  logic                       i_Next,
  input  logic                       i_Prev,
  output logic [3:0]                 o_Pattern,
  output logic                       o_Frame_Start,
  output logic [FRAME_CNT_WIDTH-1:0] o_Frame_Count
);

  localparam logic [FRAME_CNT_WIDTH-1:0] COUNT_LAST =
    FRAME_CNT_WIDTH'(FRAMES_PER_PATTERN - 1);

  logic                       frame_edge;
  logic [1:0]                 state, state_nxt, mode_nxt;
  logic [3:0]                 pattern_nxt, target, stepped;
  logic [FRAME_CNT_WIDTH-1:0] count_nxt;
  logic                       pend_vld, pend_fwd, req;
`ifdef VGA_SEQ_BLANK_EN
  logic [3:0]                 held, held_nxt;
`endif

  vga_frame_edge u_frame_edge (
    .clk         (i_Clk),
    .rst         (i_Rst),
    .vsync       (i_VSync),
    .frame_edge  (frame_edge),
    .frame_start (o_Frame_Start)
  );

  assign req      = i_Next ^ i_Prev;
  assign stepped  = step_pattern(o_Pattern, pend_fwd, NUM_PATTERNS);
  assign mode_nxt = i_Auto ? S_AUTO : S_MANUAL;

  always_comb begin
    state_nxt   = state;
    pattern_nxt = o_Pattern;
    count_nxt   = o_Frame_Count;
    target      = o_Pattern;
`ifdef VGA_SEQ_BLANK_EN
    held_nxt    = held;
`endif
    case (state)
      S_OFF: begin
        if (i_Enable) begin
          state_nxt   = mode_nxt;
          pattern_nxt = PAT_RED;
          count_nxt   = '0;
        end
      end
      S_AUTO, S_MANUAL: begin
        if (!i_Enable) begin
          state_nxt   = S_OFF;
          pattern_nxt = PAT_OFF;
          count_nxt   = '0;
        end else begin
          state_nxt = mode_nxt;
          if (mode_nxt != state) begin
            count_nxt = '0;
            if (pend_vld) target = stepped;
          end else if (state == S_AUTO) begin
            if (pend_vld) begin
              target    = stepped;
              count_nxt = '0;
            end else if (o_Frame_Count == COUNT_LAST) begin
              target    = step_pattern(o_Pattern, 1'b1, NUM_PATTERNS);
              count_nxt = '0;
            end else begin
              count_nxt = o_Frame_Count + 1'b1;
            end
          end else begin
            if (pend_vld) target = stepped;
            if (o_Frame_Count != '1) count_nxt = o_Frame_Count + 1'b1;
          end
`ifdef VGA_SEQ_BLANK_EN
          if (target != o_Pattern) begin
            state_nxt   = S_BLANK;
            pattern_nxt = PAT_OFF;
            held_nxt    = target;
            count_nxt   = '0;
          end
`else
          pattern_nxt = target;
`endif
        end
      end
`ifdef VGA_SEQ_BLANK_EN
      S_BLANK: begin
        count_nxt = '0;
        if (!i_Enable) begin
          state_nxt   = S_OFF;
          pattern_nxt = PAT_OFF;
        end else begin
          state_nxt   = mode_nxt;
          pattern_nxt = held;
        end
      end
`endif
      default: begin
        state_nxt   = S_OFF;
        pattern_nxt = PAT_OFF;
        count_nxt   = '0;
      end
    endcase
  end

  // A request in the edge cycle survives the boundary; blank frames keep theirs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= S_OFF;
      o_Pattern     <= PAT_OFF;
      o_Frame_Count <= '0;
      pend_vld      <= 1'b0;
      pend_fwd      <= 1'b0;
`ifdef VGA_SEQ_BLANK_EN
      held          <= PAT_OFF;
`endif
    end else begin
      if (req) begin
        pend_vld <= 1'b1;
        pend_fwd <= i_Next;
      end else if (frame_edge && state != S_BLANK) begin
        pend_vld <= 1'b0;
      end
      if (frame_edge) begin
        state         <= state_nxt;
        o_Pattern     <= pattern_nxt;
        o_Frame_Count <= count_nxt;
`ifdef VGA_SEQ_BLANK_EN
        held          <= held_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Frame-level bench for vga_pattern_sequencer: table of frames with a
// scoreboard of per-boundary expectations plus reset corner sequences.
module tb_vga_pattern_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_VSync = 1'b1;
  logic       i_Enable = 1'b1;
  logic       i_Auto = 1'b0;
  logic       i_Next = 1'b0;
  logic       i_Prev = 1'b0;
  logic [3:0] o_Pattern;
  logic       o_Frame_Start;
  logic [1:0] o_Frame_Count;

  vga_pattern_sequencer #(
    .NUM_PATTERNS       (7),
    .FRAMES_PER_PATTERN (3),
    .FRAME_CNT_WIDTH    (2)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_VSync       (i_VSync),
    .i_Enable      (i_Enable),
    .i_Auto        (i_Auto),
    .i_Next        (i_Next),
    .i_Prev        (i_Prev),
    .o_Pattern     (o_Pattern),
    .o_Frame_Start (o_Frame_Start),
    .o_Frame_Count (o_Frame_Count)
  );

  always #5 i_Clk = ~i_Clk;

  // req/req2 codes: 0 none, 1 next, 2 prev, 3 next+prev together
  typedef struct {
    bit en; bit au; int req; int req2; bit at_edge; int pat; int cnt;
  } vec_t;
  typedef struct { int pat; int cnt; } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   prev_rst = 1'b1;
  int   prev_pat = 0;
  int   prev_cnt = 0;

  task automatic chk(input string name, input int act, input int req_v);
    n_vec++;
    if (act != req_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req_v);
    end
  endtask

  task automatic add(input bit en, input bit au, input int req, input int req2,
                     input bit at_edge, input int pat, input int cnt);
    vec_t v;
    v = '{en, au, req, req2, at_edge, pat, cnt};
    vecs.push_back(v);
  endtask

  task automatic drive_req(input int code);
    i_Next = (code == 1 || code == 3);
    i_Prev = (code == 2 || code == 3);
  endtask

  // One frame: 6 blanking cycles with optional pulses, rising edge, 10 active cycles.
  task automatic run_frame(input vec_t v, input int idx);
    exp_t e;
    i_Enable = v.en;
    i_Auto   = v.au;
    i_VSync  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge i_Clk); #1;
      drive_req(0);
      if (!v.at_edge && c == 1) drive_req(v.req);
      if (!v.at_edge && c == 3) drive_req(v.req2);
    end
    @(posedge i_Clk); #1;
    e.pat = v.pat;
    e.cnt = v.cnt;
    exp_q.push_back(e);
    i_VSync = 1'b1;
    drive_req(v.at_edge ? v.req : 0);
    chk($sformatf("vec%0d_no_early_start", idx), int'(o_Frame_Start), 0);
    @(posedge i_Clk); #1;
    drive_req(0);
    chk($sformatf("vec%0d_frame_start", idx), int'(o_Frame_Start), 1);
    for (int c = 0; c < 10; c++) @(posedge i_Clk);
    #1;
    if (exp_q.size() != 0) begin
      chk($sformatf("vec%0d_boundary_seen", idx), exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  always @(negedge i_Clk) begin
    if (mon_en) begin
      if (i_Rst || prev_rst) begin
      end else if (o_Frame_Start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_start", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("boundary_pattern", int'(o_Pattern), e.pat);
          chk("boundary_count", int'(o_Frame_Count), e.cnt);
        end
      end else begin
        chk("pattern_stable", int'(o_Pattern), prev_pat);
        chk("count_stable", int'(o_Frame_Count), prev_cnt);
      end
      prev_pat = int'(o_Pattern);
      prev_cnt = int'(o_Frame_Count);
      prev_rst = i_Rst;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef VGA_SEQ_BLANK_EN
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 2, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 3, 0);
    add(1, 0, 0, 0, 0, 3, 1);
`else
    add(1, 0, 0, 0, 0, 1, 0);   // off -> manual, pattern 1
    add(1, 0, 1, 0, 0, 2, 1);
    add(1, 0, 2, 0, 0, 1, 2);
    add(1, 0, 2, 0, 0, 6, 3);   // prev from 1 wraps to 6
    add(1, 0, 0, 0, 0, 6, 3);   // count saturates
    add(1, 0, 1, 0, 0, 1, 3);   // next from 6 wraps to 1
    add(1, 0, 3, 0, 0, 1, 3);   // simultaneous next+prev ignored
    add(1, 0, 1, 1, 0, 2, 3);   // two nexts advance by one
    add(1, 0, 1, 2, 0, 1, 3);   // later prev overwrites next
    add(1, 1, 0, 0, 0, 1, 0);   // switch to auto clears count
    add(1, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 1, 2);
    add(1, 1, 0, 0, 0, 2, 0);
    add(1, 1, 0, 0, 0, 2, 1);
    add(1, 1, 0, 0, 0, 2, 2);
    add(1, 1, 0, 0, 0, 3, 0);
    add(1, 1, 1, 0, 0, 4, 0);   // step in auto restarts count
    add(1, 1, 0, 0, 0, 4, 1);
    add(0, 1, 0, 0, 0, 0, 0);   // disable at pattern 4
    add(0, 1, 1, 0, 0, 0, 0);   // step while off discarded
    add(1, 0, 0, 0, 0, 1, 0);   // re-enable
    add(1, 0, 1, 0, 1, 1, 1);   // request in edge cycle deferred
    add(1, 0, 0, 0, 0, 2, 2);
    add(1, 1, 1, 0, 0, 3, 0);   // mode switch still applies step
    add(1, 0, 2, 0, 0, 2, 0);
`endif
    repeat (3) @(posedge i_Clk);
    #1;
    chk("reset_pattern", int'(o_Pattern), 0);
    chk("reset_frame_start", int'(o_Frame_Start), 0);
    chk("reset_count", int'(o_Frame_Count), 0);
    i_Rst  = 1'b0;
    mon_en = 1'b1;
    repeat (8) @(posedge i_Clk);
    #1;
    chk("no_false_edge_pattern", int'(o_Pattern), 0);

    foreach (vecs[i]) run_frame(vecs[i], i);

    @(posedge i_Clk); #1;
    chk("before_midframe_reset", int'(o_Pattern == 4'd0), 0);
    i_Rst = 1'b1;
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    chk("midframe_reset_pattern", int'(o_Pattern), 0);
    chk("midframe_reset_count", int'(o_Frame_Count), 0);
    chk("midframe_reset_frame_start", int'(o_Frame_Start), 0);
    repeat (6) @(posedge i_Clk);
    #1;
    chk("post_reset_hold_pattern", int'(o_Pattern), 0);
    begin
      vec_t v;
      v = '{1'b1, 1'b0, 0, 0, 1'b0, 1, 0};
      run_frame(v, 99);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
